// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_ctrl
// Brief    : Precharge / word-line / write / sense sequencer in front of the
//            3-to-8 word-line decoder of the 8-word SRAM macro.
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int PRECHARGE_CYCLES = 1,
  parameter int WORDLINE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // array side
  output logic [2:0]            address,
  output logic                  valid,
  output logic                  precharge,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] wdata_out,
  output logic                  sense_enable,
  input  logic [DATA_WIDTH-1:0] rdata_in
);

  localparam int c_MAX_CYCLES = (PRECHARGE_CYCLES > WORDLINE_CYCLES) ?
                                PRECHARGE_CYCLES : WORDLINE_CYCLES;
  localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0] c_PRE_LOAD = c_CNT_W'(PRECHARGE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_WL_LOAD  = c_CNT_W'(WORDLINE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_WL   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic                  w_cnt_zero;
  logic                  w_accept;
  logic                  w_capture;

  logic                  r_write;
  logic [2:0]            r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  assign w_cnt_zero = (r_cnt == c_CNT_ZERO);

  // Next-state and counter control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_PRE_LOAD;
          w_state_nxt = ST_PRE;
        end
      end
      ST_PRE: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = c_WL_LOAD;
          w_state_nxt = ST_WL;
        end else begin
          w_cnt_nxt   = r_cnt - c_CNT_ONE;
        end
      end
      ST_WL: begin
        if (w_cnt_zero) begin
          w_capture   = ~r_write;
          w_state_nxt = ST_RSP;
        end else begin
          w_cnt_nxt   = r_cnt - c_CNT_ONE;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= c_CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request fields are held until the next acceptance so the decoder
  // address and write data never move under an enabled word line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= 3'd0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_capture) begin
        r_rdata <= rdata_in;
      end
    end
  end

  // Array-side outputs decode only from flops
  assign req_ready    = (r_state == ST_IDLE);
  assign valid        = (r_state == ST_WL);
  assign precharge    = (r_state != ST_WL);
  assign address      = r_addr;
  assign wdata_out    = r_wdata;
  assign write_enable = (r_state == ST_WL) & r_write;
  assign sense_enable = (r_state == ST_WL) & ~r_write & w_cnt_zero;

  assign rsp_valid    = (r_state == ST_RSP);
  assign rsp_write    = (r_state == ST_RSP) & r_write;
  assign rsp_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_ctrl
// Brief    : Directed + randomized bench for two sram_access_ctrl builds
//            (1/2 and 2/3 precharge/word-line cycles) against a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_access_ctrl;

  logic clk;
  logic reset;

  logic [1:0]      req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write;
  logic [1:0]      valid, precharge, write_enable, sense_enable;
  logic [1:0][2:0] req_addr, address;
  logic [1:0][7:0] req_wdata, rsp_rdata, wdata_out, rdata_in;

  int n_cmp;
  int n_err;
  logic [7:0] exp_rdata [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_access_ctrl #(.DATA_WIDTH(8), .PRECHARGE_CYCLES(1), .WORDLINE_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]),
    .address(address[0]), .valid(valid[0]), .precharge(precharge[0]),
    .write_enable(write_enable[0]), .wdata_out(wdata_out[0]),
    .sense_enable(sense_enable[0]), .rdata_in(rdata_in[0])
  );

  sram_access_ctrl #(.DATA_WIDTH(8), .PRECHARGE_CYCLES(2), .WORDLINE_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]),
    .address(address[1]), .valid(valid[1]), .precharge(precharge[1]),
    .write_enable(write_enable[1]), .wdata_out(wdata_out[1]),
    .sense_enable(sense_enable[1]), .rdata_in(rdata_in[1])
  );

  function automatic int p_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int w_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input int d);
    chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
    chk("rst_precharge", d, 32'(precharge[d]), 32'd1);
    chk("rst_valid", d, 32'(valid[d]), 32'd0);
    chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
    chk("rst_rsp_write", d, 32'(rsp_write[d]), 32'd0);
    chk("rst_rsp_rdata", d, 32'(rsp_rdata[d]), 32'd0);
    chk("rst_address", d, 32'(address[d]), 32'd0);
    chk("rst_we", d, 32'(write_enable[d]), 32'd0);
    chk("rst_se", d, 32'(sense_enable[d]), 32'd0);
    chk("rst_wdata_out", d, 32'(wdata_out[d]), 32'd0);
  endtask

  // One complete access, entered and left just after a falling edge.
  // Expected outputs follow from cycles elapsed since acceptance:
  // [0,P) precharge, [P,P+W) word line, then response until handshake.
  task automatic access(input int d, input bit wr, input logic [2:0] a,
                        input logic [7:0] wd, input logic [7:0] rd,
                        input int stall, input bit busy_req);
    int p;
    int w;
    p = p_of(d);
    w = w_of(d);
    chk("idle_req_ready", d, 32'(req_ready[d]), 32'd1);
    chk("idle_precharge", d, 32'(precharge[d]), 32'd1);
    chk("idle_valid", d, 32'(valid[d]), 32'd0);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    rsp_ready[d] = 1'b0;
    rdata_in[d]  = 8'($urandom);
    @(posedge clk);
    for (int t = 0; t < p + w; t++) begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = 3'($urandom);
      req_wdata[d] = 8'($urandom);
      chk("busy_req_ready", d, 32'(req_ready[d]), 32'd0);
      chk("busy_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      chk("address", d, 32'(address[d]), 32'(a));
      chk("wdata_out", d, 32'(wdata_out[d]), 32'(wd));
      if (t < p) begin
        chk("pre_precharge", d, 32'(precharge[d]), 32'd1);
        chk("pre_valid", d, 32'(valid[d]), 32'd0);
        chk("pre_we", d, 32'(write_enable[d]), 32'd0);
        chk("pre_se", d, 32'(sense_enable[d]), 32'd0);
      end else begin
        chk("wl_precharge", d, 32'(precharge[d]), 32'd0);
        chk("wl_valid", d, 32'(valid[d]), 32'd1);
        chk("wl_we", d, 32'(write_enable[d]), 32'(wr));
        chk("wl_se", d, 32'(sense_enable[d]), 32'((!wr) && (t == p + w - 1)));
      end
      rdata_in[d] = (t == p + w - 1) ? rd : 8'($urandom);
    end
    if (!wr) exp_rdata[d] = rd;
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      chk("rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
      chk("rsp_write", d, 32'(rsp_write[d]), 32'(wr));
      chk("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(exp_rdata[d]));
      chk("rsp_req_ready", d, 32'(req_ready[d]), 32'd0);
      chk("rsp_valid_wl", d, 32'(valid[d]), 32'd0);
      chk("rsp_precharge", d, 32'(precharge[d]), 32'd1);
      chk("rsp_we", d, 32'(write_enable[d]), 32'd0);
      chk("rsp_se", d, 32'(sense_enable[d]), 32'd0);
      chk("rsp_address", d, 32'(address[d]), 32'(a));
      rdata_in[d] = 8'($urandom);
      if (busy_req) begin
        req_valid[d] = 1'b1;
        req_addr[d]  = ~a;
        req_write[d] = ~wr;
        req_wdata[d] = ~wd;
      end
      rsp_ready[d] = (s == stall);
    end
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("post_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
    chk("post_req_ready", d, 32'(req_ready[d]), 32'd1);
    chk("post_precharge", d, 32'(precharge[d]), 32'd1);
    chk("post_rsp_rdata", d, 32'(rsp_rdata[d]), 32'(exp_rdata[d]));
    if (!busy_req) req_valid[d] = 1'b0;
  endtask

  // Array-side invariants sampled every cycle on both builds
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        chk("excl_valid_precharge", d, 32'(valid[d] & precharge[d]), 32'd0);
        chk("excl_we_se", d, 32'(write_enable[d] & sense_enable[d]), 32'd0);
        chk("en_without_valid", d, 32'((write_enable[d] | sense_enable[d]) & ~valid[d]), 32'd0);
      end
    end
  end

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b0;
    req_valid    = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = '0;
    rdata_in     = '0;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;

    // Reset applied between clock edges takes effect immediately
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk_reset_values(d);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Default build: read, write, back-pressure with a pending request
    access(0, 1'b0, 3'd5, 8'h00, 8'hA5, 0, 1'b0);
    access(0, 1'b1, 3'd3, 8'h3C, 8'h00, 0, 1'b0);
    access(0, 1'b0, 3'd1, 8'h11, 8'h5A, 10, 1'b1);
    access(0, 1'b1, 3'd6, 8'hC3, 8'h00, 0, 1'b0);

    // Reset during the word-line phase discards the access
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 3'd7;
    req_wdata[0] = 8'h77;
    rdata_in[0]  = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_reset_in_wl", 0, 32'(valid[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_reset_values(0);
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 0, 32'(rsp_valid[0]), 32'd0);
      chk("idle_after_reset", 0, 32'(req_ready[0]), 32'd1);
    end
    access(0, 1'b0, 3'd2, 8'h00, 8'h96, 0, 1'b0);

    // Longer build: read, write, back-pressure
    access(1, 1'b0, 3'd4, 8'h00, 8'h69, 0, 1'b0);
    access(1, 1'b1, 3'd0, 8'hF0, 8'h00, 2, 1'b0);
    access(1, 1'b0, 3'd7, 8'h00, 8'h0F, 10, 1'b1);
    access(1, 1'b1, 3'd2, 8'h44, 8'h00, 0, 1'b0);

    // Randomized traffic on both builds
    for (int i = 0; i < 40; i++) begin
      access(i % 2, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Access sequencer that sits directly upstream of the 3-to-8 word-line decoder in the 8-word SRAM macro.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences bitline precharge, word-line enable (decoder address/valid), write enable and sense enable with registered timing.
- Returns read data or write completion over a valid/ready response handshake.

Parameters:
DATA_WIDTH, 8, bits per word (bitline pairs).
PRECHARGE_CYCLES, 1, cycles bitlines are precharged before word-line enable; legal range >=1.
WORDLINE_CYCLES, 2, cycles the word line stays enabled; legal range >=1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_write  input  1  1 = write, 0 = read.
req_addr  input  3  word address 0..7.
req_wdata  input  DATA_WIDTH  write data.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_write  output  1  echo of the latched req_write.
rsp_rdata  output  DATA_WIDTH  read data; holds its previous value for writes.
address  output  3  to decoder address input.
valid  output  1  to decoder valid input (word-line enable).
precharge  output  1  bitline precharge enable.
write_enable  output  1  write driver enable.
wdata_out  output  DATA_WIDTH  write driver data.
sense_enable  output  1  sense amplifier enable.
rdata_in  input  DATA_WIDTH  sense amplifier output.

Behaviour:
- States: IDLE, PRE, WL, RSP. A down-counter sized to max(PRECHARGE_CYCLES, WORDLINE_CYCLES) times PRE and WL.
- All array-side outputs are decoded from state/flop registers only. There is no combinational path from any req_* or rsp_ready input to address, valid, precharge, write_enable, sense_enable or wdata_out.
- Reset (asynchronous, any state) forces:
  - state = IDLE
  - req_ready = 1, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0
  - address = 0, valid = 0, precharge = 1, write_enable = 0, sense_enable = 0, wdata_out = 0
  - Any in-flight request is discarded; no response is produced for it.

State behaviour:
- IDLE
  - req_ready = 1, precharge = 1.
  - On req_valid & req_ready at an edge: latch req_addr into address, req_write, and req_wdata into wdata_out. Load the counter with PRECHARGE_CYCLES-1 and go to PRE.
- PRE
  - req_ready = 0, precharge = 1, valid = 0.
  - When the counter reaches 0: load WORDLINE_CYCLES-1 and go to WL.
- WL
  - precharge = 0, valid = 1, address = latched address.
  - write_enable = latched write for every WL cycle.
  - sense_enable = 1 only on the final WL cycle (counter = 0), and only for reads.
  - At the edge ending the final WL cycle: for reads, capture rdata_in into rsp_rdata. Go to RSP.
- RSP
  - rsp_valid = 1, rsp_write = latched write, valid = 0, precharge = 1.
  - On rsp_valid & rsp_ready: go to IDLE.
  - rsp_ready held low: stay in RSP indefinitely with outputs stable and the array idle.

Timing and ordering:
- address and wdata_out remain stable from acceptance until the next acceptance; they never change while valid = 1.
- Latency: with acceptance at edge E0, valid is high for WORDLINE_CYCLES cycles starting at edge E0+PRECHARGE_CYCLES. rsp_valid rises at edge E0+PRECHARGE_CYCLES+WORDLINE_CYCLES.
- req_ready is 0 in PRE, WL and RSP. Requests presented then are ignored and must be held by the requester.
- Earliest next acceptance is one cycle after the response handshake. Minimum period is PRECHARGE_CYCLES+WORDLINE_CYCLES+2 cycles.
- valid and precharge are never 1 in the same cycle.
- write_enable and sense_enable are never 1 in the same cycle, and are never 1 while valid = 0.

Test Plan:
1. Reset values: assert reset mid-cycle without a clock edge -> all outputs take their reset values immediately (precharge = 1, req_ready = 1, others 0).
2. Read, defaults: read of addr 5 with rdata_in = 0xA5 accepted at E0 -> precharge low and valid = 1/address = 5 over E1..E3; sense_enable only in the E2..E3 cycle; rsp_valid at E3 with rsp_rdata = 0xA5 and rsp_write = 0.
3. Write: write of addr 3, data 0x3C -> write_enable = 1 and wdata_out = 0x3C for both WL cycles; sense_enable never 1; rsp_write = 1 and rsp_rdata unchanged.
4. Back-pressure and busy: hold rsp_ready = 0 for 10 cycles while a second request is presented -> rsp_valid stays 1 and req_ready stays 0; the second request is accepted exactly one cycle after the rsp handshake.
5. Reset mid-access: assert reset during WL -> valid drops to 0 and precharge rises to 1 asynchronously; no response is produced; the next read returns correct data.
6. Parameters PRECHARGE_CYCLES = 2, WORDLINE_CYCLES = 3 -> valid high for exactly 3 cycles starting 2 cycles after acceptance; rsp_valid 5 cycles after acceptance; the valid/precharge exclusivity assertion holds throughout.
